// File: rtl/syzygy_adc_frame_tx_pkg.sv
// Shared constants and lane-split helpers for the SYZYGY ADC frame transmitter.
package syzygy_adc_tx_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_TRAIN = 2'd1,
        MODE_DATA  = 2'd2,
        MODE_RAMP  = 2'd3
    } mode_e;

    localparam logic [7:0]  FRAME_WORD   = 8'hF0;
    localparam logic [15:0] TRAIN_SAMPLE = 16'hCCCC;

    // Odd sample bits, MSB-first: s[15], s[13], ... s[1]
    function automatic logic [7:0] odd_bits(input logic [15:0] s);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) r[i] = s[2*i+1];
        return r;
    endfunction

    // Even sample bits, MSB-first: s[14], s[12], ... s[0]
    function automatic logic [7:0] even_bits(input logic [15:0] s);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) r[i] = s[2*i];
        return r;
    endfunction

endpackage

// File: rtl/syzygy_adc_frame_tx_if.sv
// Sample input handshake plus serializer-facing word outputs of the frame transmitter.
interface syzygy_adc_frame_tx_if;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  frame_word;
    logic [7:0]  lane0_word;
    logic [7:0]  lane1_word;
    logic        tx_valid;

    modport master (
        output s_data, s_valid,
        input  s_ready, frame_word, lane0_word, lane1_word, tx_valid
    );

    modport slave (
        input  s_data, s_valid,
        output s_ready, frame_word, lane0_word, lane1_word, tx_valid
    );
endinterface

// File: rtl/syzygy_adc_frame_tx_bitslip_inject.sv
// One lane of slip injection: holds the previous and current raw word and emits
// the 16-bit pair shifted right by the slip amount, delaying the serial stream.
module bitslip_inject (
    input  logic       slow_clk,
    input  logic       reset,
    input  logic       ena,
    input  logic [7:0] raw_word,
    input  logic [2:0] slip,
    output logic [7:0] out_word
);
    logic [7:0] cur_r;
    logic [7:0] prev_r;
    logic [7:0] out_r;

    // Word pair history and rotated output register; ena low clears the history
    always_ff @(posedge slow_clk or posedge reset) begin
        if (reset) begin
            cur_r  <= 8'h00;
            prev_r <= 8'h00;
            out_r  <= 8'h00;
        end else if (!ena) begin
            cur_r  <= 8'h00;
            prev_r <= 8'h00;
            out_r  <= 8'h00;
        end else begin
            prev_r <= cur_r;
            cur_r  <= raw_word;
            out_r  <= 8'({prev_r, cur_r} >> slip);
        end
    end

    assign out_word = out_r;
endmodule

// File: rtl/syzygy_adc_frame_tx.sv
// SYZYGY ADC frame transmitter: picks a 16-bit sample per slow_clk cycle, splits it
// into two 8-bit lanes beside a constant frame lane, and applies programmable slip.
module syzygy_adc_frame_tx
    import syzygy_adc_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int UFLOW_W    = 16
) (
    input  logic                 slow_clk,
    input  logic                 reset,
    input  logic                 ena,
    input  logic [1:0]           mode,
    input  logic [2:0]           slip_offset,
    syzygy_adc_frame_tx_if.slave tx,
    output logic [UFLOW_W-1:0]   underflow_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    mode_e              mode_s;
    logic [15:0]        fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               full_s;
    logic               empty_s;
    logic               ready_s;
    logic               push_s;
    logic               pop_s;
    logic               uflow_s;
    logic [15:0]        ramp_r;
    logic [15:0]        sample_s;
    logic [2:0]         slip_r;
    logic               cur_valid_r;
    logic               tx_valid_r;
    logic [UFLOW_W-1:0] uflow_r;

    assign mode_s  = mode_e'(mode);
    assign full_s  = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty_s = (count_r == {CNT_W{1'b0}});
    // Reset gates ready so no push can be offered while state is held cleared
    assign ready_s = ena && !full_s && !reset;
    assign push_s  = tx.s_valid && ready_s;
    assign pop_s   = ena && (mode_s == MODE_DATA) && !empty_s;
    assign uflow_s = ena && (mode_s == MODE_DATA) && empty_s;

    // Source select for the word generated this cycle
    always_comb begin
        sample_s = 16'h0000;
        case (mode_s)
            MODE_IDLE:  sample_s = 16'h0000;
            MODE_TRAIN: sample_s = TRAIN_SAMPLE;
            MODE_DATA:  sample_s = empty_s ? 16'h0000 : fifo_mem_r[rd_ptr_r];
            MODE_RAMP:  sample_s = ramp_r;
            default:    sample_s = 16'h0000;
        endcase
    end

    // Sample storage; validity is tracked by the pointers, so no reset is needed
    always_ff @(posedge slow_clk) begin
        if (push_s) fifo_mem_r[wr_ptr_r] <= tx.s_data;
    end

    // FIFO pointers and occupancy; ena low flushes
    always_ff @(posedge slow_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (!ena) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Ramp source and the two-stage valid pipeline
    always_ff @(posedge slow_clk or posedge reset) begin
        if (reset) begin
            ramp_r      <= 16'h0000;
            cur_valid_r <= 1'b0;
            tx_valid_r  <= 1'b0;
        end else begin
            cur_valid_r <= ena;
            tx_valid_r  <= ena && cur_valid_r;
            if (!ena) ramp_r <= 16'h0000;
            else if (mode_s == MODE_RAMP) ramp_r <= ramp_r + 16'h0001;
        end
    end

    // Saturating underflow counter; only reset clears it
    always_ff @(posedge slow_clk or posedge reset) begin
        if (reset) uflow_r <= {UFLOW_W{1'b0}};
        else if (uflow_s && (uflow_r != {UFLOW_W{1'b1}})) uflow_r <= uflow_r + UFLOW_W'(1);
    end

    // Slip is registered alongside the raw words so both reach the rotator together
    always_ff @(posedge slow_clk or posedge reset) begin
        if (reset) slip_r <= 3'd0;
        else slip_r <= slip_offset;
    end

    bitslip_inject u_frame (
        .slow_clk(slow_clk), .reset(reset), .ena(ena),
        .raw_word(FRAME_WORD), .slip(slip_r), .out_word(tx.frame_word)
    );
    bitslip_inject u_lane0 (
        .slow_clk(slow_clk), .reset(reset), .ena(ena),
        .raw_word(even_bits(sample_s)), .slip(slip_r), .out_word(tx.lane0_word)
    );
    bitslip_inject u_lane1 (
        .slow_clk(slow_clk), .reset(reset), .ena(ena),
        .raw_word(odd_bits(sample_s)), .slip(slip_r), .out_word(tx.lane1_word)
    );

    assign tx.s_ready       = ready_s;
    assign tx.tx_valid      = tx_valid_r;
    assign underflow_count  = uflow_r;
endmodule

// File: tb/tb_syzygy_adc_frame_tx.sv
// Bench for syzygy_adc_frame_tx: per-scenario tasks checked against a cycle-history
// model built from the framing, FIFO, underflow and slip rules.
module tb_syzygy_adc_frame_tx;
    localparam int DEPTH = 4;
    localparam int UFW   = 4;
    localparam int UMAX  = 15;

    logic           slow_clk = 1'b0;
    logic           reset = 1'b1;
    logic           ena = 1'b0;
    logic [1:0]     mode = 2'd0;
    logic [2:0]     slip_offset = 3'd0;
    logic [UFW-1:0] underflow_count;
    logic [24:0]    got;

    syzygy_adc_frame_tx_if bus ();

    syzygy_adc_frame_tx #(.FIFO_DEPTH(DEPTH), .UFLOW_W(UFW)) dut (
        .slow_clk(slow_clk), .reset(reset), .ena(ena), .mode(mode),
        .slip_offset(slip_offset), .tx(bus), .underflow_count(underflow_count)
    );

    always #5 slow_clk = ~slow_clk;

    assign got = {bus.tx_valid, bus.frame_word, bus.lane1_word, bus.lane0_word};

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: pending samples, counters, and the last two generated raw words
    logic [15:0] q[$];
    int          uf_m;
    int          ramp_m;
    logic [23:0] h1, h2;
    logic        e1;
    logic [2:0]  slip1;
    logic [24:0] exp_out;

    function automatic logic [7:0] pick_bits(input logic [15:0] s, input int start);
        int v = 0;
        for (int j = 0; j < 8; j++) v += ((int'(s) >> (2*j + start)) & 1) << j;
        return 8'(v);
    endfunction

    function automatic logic [7:0] rot(input logic [7:0] p, input logic [7:0] c, input logic [2:0] sh);
        int v;
        v = ((int'(p) << 8) | int'(c)) >> int'(sh);
        return 8'(v & 255);
    endfunction

    function automatic logic [23:0] raw_word(input logic [15:0] s);
        return {8'hF0, pick_bits(s, 1), pick_bits(s, 0)};
    endfunction

    function automatic logic exp_ready();
        return ena && !reset && (q.size() < DEPTH);
    endfunction

    task automatic model_reset();
        q.delete();
        uf_m = 0; ramp_m = 0; h1 = 24'h0; h2 = 24'h0; e1 = 1'b0; slip1 = 3'd0; exp_out = 25'h0;
    endtask

    task automatic tick();
        logic [15:0] smp;
        logic        acc;
        @(posedge slow_clk);
        if (reset) begin
            model_reset();
        end else begin
            if (ena && e1)
                exp_out = {1'b1, rot(h2[23:16], h1[23:16], slip1),
                           rot(h2[15:8], h1[15:8], slip1), rot(h2[7:0], h1[7:0], slip1)};
            else
                exp_out = 25'h0;
            if (ena) begin
                acc = bus.s_valid && (q.size() < DEPTH);
                smp = 16'h0000;
                case (mode)
                    2'd1: smp = 16'hCCCC;
                    2'd2: if (q.size() > 0) smp = q.pop_front();
                          else if (uf_m < UMAX) uf_m++;
                    2'd3: begin smp = 16'(ramp_m); ramp_m = (ramp_m + 1) % 65536; end
                    default: smp = 16'h0000;
                endcase
                if (acc) q.push_back(bus.s_data);
                h2 = h1; h1 = raw_word(smp);
            end else begin
                q.delete(); ramp_m = 0; h2 = h1; h1 = 24'h0;
            end
            e1 = ena; slip1 = slip_offset;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++; if (got !== 25'h0) begin n_bad++; $display("FAIL reset_out got=%h exp=%h", got, 25'h0); end
            n_cmp++; if (bus.s_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b exp=0", bus.s_ready); end
            n_cmp++; if (underflow_count !== 4'h0) begin n_bad++; $display("FAIL reset_uflow got=%h exp=0", underflow_count); end
        end
        reset = 1'b0;
        tick();
        n_cmp++; if (got !== exp_out) begin n_bad++; $display("FAIL post_reset_out got=%h exp=%h", got, exp_out); end
    endtask

    task automatic test_ramp();
        mode = 2'd3; slip_offset = 3'd0; ena = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_cmp++; if (got !== exp_out) begin n_bad++; $display("FAIL ramp_out k=%0d got=%h exp=%h", k, got, exp_out); end
            if (k == 2) begin
                n_cmp++; if (got !== {1'b1, 8'hF0, 16'h0000}) begin n_bad++; $display("FAIL ramp_first k=2 got=%h exp=%h", got, {1'b1, 8'hF0, 16'h0000}); end
            end
            if (k == 3) begin
                n_cmp++; if (got !== {1'b1, 8'hF0, 8'h00, 8'h01}) begin n_bad++; $display("FAIL ramp_s1 got=%h exp=%h", got, {1'b1, 8'hF0, 8'h00, 8'h01}); end
            end
            if (k == 5) begin
                n_cmp++; if (got !== {1'b1, 8'hF0, 8'h01, 8'h01}) begin n_bad++; $display("FAIL ramp_s3 got=%h exp=%h", got, {1'b1, 8'hF0, 8'h01, 8'h01}); end
            end
        end
    endtask

    task automatic test_train_slip();
        mode = 2'd1; slip_offset = 3'd3;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_cmp++; if (got !== exp_out) begin n_bad++; $display("FAIL train_slip3 k=%0d got=%h exp=%h", k, got, exp_out); end
        end
        n_cmp++; if (got !== {1'b1, 8'h1E, 8'h55, 8'h55}) begin n_bad++; $display("FAIL train_slip3_settled got=%h exp=%h", got, {1'b1, 8'h1E, 8'h55, 8'h55}); end
        slip_offset = 3'd0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_cmp++; if (got !== exp_out) begin n_bad++; $display("FAIL train_slip0 k=%0d got=%h exp=%h", k, got, exp_out); end
        end
        n_cmp++; if (got !== {1'b1, 8'hF0, 8'hAA, 8'hAA}) begin n_bad++; $display("FAIL train_slip0_settled got=%h exp=%h", got, {1'b1, 8'hF0, 8'hAA, 8'hAA}); end
    endtask

    task automatic test_data();
        logic [15:0] vals  [4] = '{16'h8001, 16'h0002, 16'h0000, 16'hFFFF};
        logic [15:0] pairs [4] = '{16'h8001, 16'h0100, 16'h0000, 16'hFFFF};
        for (int i = 0; i < 4; i++) begin
            bus.s_valid = 1'b1; bus.s_data = vals[i];
            tick();
        end
        bus.s_valid = 1'b0; mode = 2'd2;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_cmp++; if (got !== exp_out) begin n_bad++; $display("FAIL data_out k=%0d got=%h exp=%h", k, got, exp_out); end
            n_cmp++; if (underflow_count !== 4'(uf_m)) begin n_bad++; $display("FAIL data_uflow k=%0d got=%0d exp=%0d", k, underflow_count, uf_m); end
            if (k >= 2 && k <= 5) begin
                n_cmp++; if (got[15:0] !== pairs[k-2]) begin n_bad++; $display("FAIL data_order k=%0d got=%h exp=%h", k, got[15:0], pairs[k-2]); end
            end
            if (k == 5) begin
                n_cmp++; if (underflow_count !== 4'd1) begin n_bad++; $display("FAIL data_first_uflow got=%0d exp=1", underflow_count); end
            end
        end
    endtask

    task automatic test_fifo_full();
        ena = 1'b0;
        tick();
        ena = 1'b1; mode = 2'd1;
        for (int i = 0; i < 5; i++) begin
            bus.s_valid = 1'b1; bus.s_data = 16'($urandom);
            #1;
            n_cmp++; if (bus.s_ready !== exp_ready()) begin n_bad++; $display("FAIL full_ready i=%0d got=%b exp=%b", i, bus.s_ready, exp_ready()); end
            n_cmp++; if (bus.s_ready !== (i < 4)) begin n_bad++; $display("FAIL full_ready_const i=%0d got=%b exp=%b", i, bus.s_ready, i < 4); end
            tick();
        end
        bus.s_valid = 1'b0; mode = 2'd2;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_cmp++; if (got !== exp_out) begin n_bad++; $display("FAIL full_drain k=%0d got=%h exp=%h", k, got, exp_out); end
        end
    endtask

    task automatic test_saturation();
        mode = 2'd2; bus.s_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_cmp++; if (underflow_count !== 4'(uf_m)) begin n_bad++; $display("FAIL sat_uflow k=%0d got=%0d exp=%0d", k, underflow_count, uf_m); end
        end
        n_cmp++; if (underflow_count !== 4'hF) begin n_bad++; $display("FAIL sat_final got=%h exp=f", underflow_count); end
    endtask

    task automatic test_reset_mid();
        mode = 2'd1;
        for (int i = 0; i < 3; i++) begin
            bus.s_valid = 1'b1; bus.s_data = 16'($urandom);
            tick();
        end
        bus.s_valid = 1'b0; mode = 2'd2;
        tick();
        reset = 1'b1;
        model_reset();
        #1;
        n_cmp++; if (got !== 25'h0) begin n_bad++; $display("FAIL rstmid_out got=%h exp=0", got); end
        n_cmp++; if (bus.s_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_ready got=%b exp=0", bus.s_ready); end
        n_cmp++; if (underflow_count !== 4'h0) begin n_bad++; $display("FAIL rstmid_uflow got=%h exp=0", underflow_count); end
        tick(); tick();
        n_cmp++; if (got !== 25'h0) begin n_bad++; $display("FAIL rstmid_hold got=%h exp=0", got); end
        reset = 1'b0;
        tick();
        n_cmp++; if (underflow_count !== 4'd1) begin n_bad++; $display("FAIL rstmid_first_uflow got=%0d exp=1", underflow_count); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_cmp++; if (got !== exp_out) begin n_bad++; $display("FAIL rstmid_out k=%0d got=%h exp=%h", k, got, exp_out); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            ena = ($urandom_range(0, 9) != 0);
            mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) slip_offset = 3'($urandom_range(0, 7));
            bus.s_valid = 1'($urandom_range(0, 1));
            bus.s_data = 16'($urandom);
            #1;
            n_cmp++; if (bus.s_ready !== exp_ready()) begin n_bad++; $display("FAIL rand_ready k=%0d got=%b exp=%b", k, bus.s_ready, exp_ready()); end
            tick();
            n_cmp++; if (got !== exp_out) begin n_bad++; $display("FAIL rand_out k=%0d got=%h exp=%h", k, got, exp_out); end
            n_cmp++; if (underflow_count !== 4'(uf_m)) begin n_bad++; $display("FAIL rand_uflow k=%0d got=%0d exp=%0d", k, underflow_count, uf_m); end
        end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data = 16'h0000;
        model_reset();
        test_reset();
        test_ramp();
        test_train_slip();
        test_data();
        test_fifo_full();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
